muldiv_sequencer: RTL and testbench
===================================

# muldiv_sequencer

Multi-cycle sequencer for the signed MULT/DIV path of the single-issue MIPS core. It accepts an operation when the decoder presents R-type funct MULT (6'b011000) or DIV (6'b011010). It then runs an iterative 32-step shift-add multiply or restoring divide, holds the core via `busy`, and writes the HI/LO result registers. HI/LO hold their value until the next completion, so later instructions can read them.

## Interface

Parameters:
- `WIDTH`, 32: operand width. HI and LO are each `WIDTH` bits wide.

Ports:
- `clk`  in  1  clock. All state updates on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `start`  in  1  request strobe from the decoder.
- `func`  in  6  R-type funct field, qualified by `start`.
- `rs_data`  in  WIDTH  multiplicand or dividend.
- `rt_data`  in  WIDTH  multiplier or divisor.
- `busy`  out  1  high in every state except IDLE. The core stalls fetch/issue while it is high.
- `done`  out  1  one-cycle pulse when `hi`/`lo` hold a new result.
- `div_zero`  out  1  sticky flag. Set by a DIV with `rt_data`==0; cleared by the next accepted operation.
- `hi`  out  WIDTH  upper product, or remainder.
- `lo`  out  WIDTH  lower product, or quotient.

## Operation

States are IDLE, RUN, FIX and DONE.

- **IDLE:**
  - Accept the request when `start`=1 and `func` is MULT or DIV.
  - Any other `func` with `start` is ignored: no state change, no output change.
  - On accept, latch the operation type and the operand magnitudes |rs| and |rt| (two's-complement absolute value).
  - Latch the result sign:
    - MULT: rs[31]^rt[31].
    - DIV quotient: rs[31]^rt[31].
    - DIV remainder: rs[31].
  - Clear the 6-bit step counter and clear `div_zero`. Go to RUN.
- **Divide by zero:** if the operation is DIV and `rt_data`==0, go directly to DONE instead of RUN.
  - Set `div_zero`=1.
  - Load `lo`=all-ones and `hi`=`rs_data`.
- **RUN, MULT:** each cycle, if bit 0 of the multiplier shift register is 1, add the multiplicand into the upper half of a 2*WIDTH accumulator. Then shift the {carry, acc, multiplier} register right by 1.
- **RUN, DIV:** restoring divide, one quotient bit per cycle.
  - Shift the {rem, dividend} register left by 1.
  - Compute trial = rem - divisor using a WIDTH+1-bit subtraction.
  - If trial is non-negative, rem = trial and shift in a quotient bit of 1; otherwise keep rem and shift in 0.
- **RUN exit:** after exactly WIDTH steps (counter reaches WIDTH-1), go to FIX.
- **FIX:** apply the latched signs by two's-complement negation.
  - MULT: negate the full 2*WIDTH product.
  - DIV: negate quotient and remainder independently.
  - Register the results into `hi`/`lo`. Go to DONE.
- **DONE:** `done`=1 for this one cycle, then IDLE.
- **Arithmetic edge cases:**
  - All arithmetic wraps modulo 2^WIDTH per half.
  - 0x80000000 / -1 gives `lo`=0x80000000, `hi`=0.
  - The remainder sign always follows the dividend.
- **Start while busy:** `start` is ignored in RUN, FIX and DONE. The operands and `func` present in those cycles have no effect.
- **Reset:**
  - Reset at any cycle, including mid-RUN, forces IDLE and aborts the operation.
  - Reset clears `hi`, `lo`, the counter and the internal registers to 0.
  - Reset drives `busy`, `done` and `div_zero` to 0.
  - Reset takes priority over `start` in the same cycle.

## Timing

- Request accepted on edge E0, where `start` is sampled in IDLE.
- RUN occupies cycles E1..E32. FIX is E33. DONE is E34.
- `done` is high in E34, and `hi`/`lo` are valid from E34 on. Latency from accept to result is 34 cycles.
- `busy` is high from E1 through E34 and low again in E35. The earliest new accept is at E35.
- For divide by zero: DONE in E1, `done` pulses in E1, `busy` is high only in E1.
- `hi`/`lo` change only on the FIX→DONE transition, the IDLE→DONE (divide-by-zero) transition, or reset.
- The outputs are glitch-free registers. `busy` and `done` are decoded from the state register only.

## Test plan

- **MULT 7 × -3:** `start` with func=011000, rs=7, rt=0xFFFFFFFD.
  - `done` exactly 34 cycles after accept.
  - `hi`=0xFFFFFFFF, `lo`=0xFFFFFFEB.
  - `busy` high for exactly 34 cycles.
- **DIV -7 / 2:** `lo`=0xFFFFFFFD (-3), `hi`=0xFFFFFFFF (-1), `div_zero`=0.
- **Signed-overflow DIV:** DIV 0x80000000 / 0xFFFFFFFF gives `lo`=0x80000000, `hi`=0. Also, MULT 0x80000000 × 0x80000000 gives `hi`=0x40000000, `lo`=0.
- **Divide by zero:** DIV 5 / 0.
  - `done` and `busy` in the next cycle only.
  - `lo`=0xFFFFFFFF, `hi`=5, `div_zero`=1.
  - A following MULT 2×3 clears `div_zero` and gives `lo`=6.
- **Start while busy:** a second `start` at cycle E10 with different operands has no effect. The first result is unchanged, and `busy` falls at E35. A `start` with func=100000 (ADD) in IDLE leaves `busy` at 0.
- **Reset mid-operation:** assert `reset` at E15 of a MULT.
  - The next cycle shows `busy`=0, `done`=0, `hi`=`lo`=0.
  - A fresh DIV 100 / 7 then gives `lo`=14, `hi`=2.

Source files
------------

// File: rtl/muldiv_sequencer_if.sv
// muldiv_sequencer_if: decoder/core side (master) to MULT/DIV sequencer (slave): request, operands, busy/done/div_zero and HI/LO results
interface muldiv_sequencer_if #(parameter int WIDTH = 32);
  logic             start;
  logic [5:0]       func;
  logic [WIDTH-1:0] rs_data;
  logic [WIDTH-1:0] rt_data;
  logic             busy;
  logic             done;
  logic             div_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  modport master(output start, func, rs_data, rt_data, input busy, done, div_zero, hi, lo);
  modport slave(input start, func, rs_data, rt_data, output busy, done, div_zero, hi, lo);
endinterface

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: iterative signed MULT/DIV (clk, sync active-high reset, bus m: start/func/rs_data/rt_data in; busy/done/div_zero/hi/lo out)
module muldiv_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic           clk,
  input  logic           reset,
  muldiv_sequencer_if.slave m
);
  localparam logic [5:0] FUNC_MULT = 6'b011000;
  localparam logic [5:0] FUNC_DIV  = 6'b011010;
  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;
  state_t               state_q, state_d;
  logic                 is_div_q, is_div_d;
  logic                 neg_lo_q, neg_lo_d;
  logic                 neg_hi_q, neg_hi_d;
  logic                 dz_q, dz_d;
  logic [5:0]           cnt_q, cnt_d;
  logic [WIDTH-1:0]     b_q, b_d;
  logic [WIDTH-1:0]     hi_q, hi_d;
  logic [WIDTH-1:0]     lo_q, lo_d;
  logic [2*WIDTH-1:0]   p_q, p_d;
  logic                 accept, is_div_in;
  logic [WIDTH-1:0]     abs_rs, abs_rt;
  logic [WIDTH:0]       msum, trial;
  logic [2*WIDTH-1:0]   mult_next, div_next, prod_fix;
  logic [WIDTH-1:0]     q_fix, r_fix;
  assign m.busy     = state_q != IDLE;
  assign m.done     = state_q == DONE;
  assign m.div_zero = dz_q;
  assign m.hi       = hi_q;
  assign m.lo       = lo_q;
  always_comb begin
    accept    = state_q == IDLE && m.start && (m.func == FUNC_MULT || m.func == FUNC_DIV);
    is_div_in = m.func == FUNC_DIV;
    abs_rs    = m.rs_data[WIDTH-1] ? -m.rs_data : m.rs_data;
    abs_rt    = m.rt_data[WIDTH-1] ? -m.rt_data : m.rt_data;
    // p_q holds {acc, multiplier} for MULT and {rem, dividend} for DIV
    msum      = {1'b0, p_q[2*WIDTH-1:WIDTH]} + (p_q[0] ? {1'b0, b_q} : '0);
    mult_next = {msum, p_q[WIDTH-1:1]};
    trial     = {1'b0, p_q[2*WIDTH-2:WIDTH-1]} - {1'b0, b_q};
    div_next  = {trial[WIDTH] ? p_q[2*WIDTH-2:WIDTH-1] : trial[WIDTH-1:0], p_q[WIDTH-2:0], ~trial[WIDTH]};
    prod_fix  = neg_lo_q ? -p_q : p_q;
    q_fix     = neg_lo_q ? -p_q[WIDTH-1:0] : p_q[WIDTH-1:0];
    r_fix     = neg_hi_q ? -p_q[2*WIDTH-1:WIDTH] : p_q[2*WIDTH-1:WIDTH];
    state_d   = state_q;
    is_div_d  = is_div_q;
    neg_lo_d  = neg_lo_q;
    neg_hi_d  = neg_hi_q;
    dz_d      = dz_q;
    cnt_d     = cnt_q;
    b_d       = b_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    p_d       = p_q;
    if (accept) begin
      is_div_d = is_div_in;
      neg_lo_d = m.rs_data[WIDTH-1] ^ m.rt_data[WIDTH-1];
      neg_hi_d = is_div_in ? m.rs_data[WIDTH-1] : m.rs_data[WIDTH-1] ^ m.rt_data[WIDTH-1];
      b_d      = is_div_in ? abs_rt : abs_rs;
      p_d      = {{WIDTH{1'b0}}, is_div_in ? abs_rs : abs_rt};
      cnt_d    = '0;
      dz_d     = is_div_in && m.rt_data == '0;
      state_d  = dz_d ? DONE : RUN;
      hi_d     = dz_d ? m.rs_data : hi_q;
      lo_d     = dz_d ? '1 : lo_q;
    end else if (state_q == RUN) begin
      p_d     = is_div_q ? div_next : mult_next;
      cnt_d   = cnt_q + 6'd1;
      state_d = cnt_q == 6'(WIDTH-1) ? FIX : RUN;
    end else if (state_q == FIX) begin
      hi_d    = is_div_q ? r_fix : prod_fix[2*WIDTH-1:WIDTH];
      lo_d    = is_div_q ? q_fix : prod_fix[WIDTH-1:0];
      state_d = DONE;
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      is_div_q <= 1'b0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      dz_q     <= 1'b0;
      cnt_q    <= '0;
      b_q      <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      p_q      <= '0;
    end else begin
      state_q  <= state_d;
      is_div_q <= is_div_d;
      neg_lo_q <= neg_lo_d;
      neg_hi_q <= neg_hi_d;
      dz_q     <= dz_d;
      cnt_q    <= cnt_d;
      b_q      <= b_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      p_q      <= p_d;
    end
  end
endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb_muldiv_sequencer: directed stimulus with a scoreboard queue checked by a done-driven monitor
module tb_muldiv_sequencer;
  localparam logic [5:0] MULT = 6'b011000;
  localparam logic [5:0] DIV  = 6'b011010;
  localparam logic [5:0] ADD  = 6'b100000;
  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
    int          lat;
  } exp_t;
  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errs = 0;
  exp_t sb[$];
  muldiv_sequencer_if #(.WIDTH(32)) bus();
  muldiv_sequencer #(.WIDTH(32)) dut(.clk(clk), .reset(reset), .m(bus.slave));
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  int busy_run = 0;
  bit prev_done = 0;
  always @(negedge clk) begin
    exp_t e;
    if (prev_done) chk("busy_after_done", {31'b0, bus.busy}, 32'd0);
    prev_done = bus.done === 1'b1;
    busy_run = bus.busy === 1'b1 ? busy_run + 1 : 0;
    if (bus.done === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errs++;
        $display("FAIL unexpected_done: got done=1 expected no result pending at %0t", $time);
      end else begin
        e = sb.pop_front();
        chk("hi", bus.hi, e.hi);
        chk("lo", bus.lo, e.lo);
        chk("div_zero", {31'b0, bus.div_zero}, {31'b0, e.dz});
        chk("busy_cycles", busy_run, e.lat);
      end
    end
  end
  task automatic issue(input logic [5:0] f, input logic [31:0] rs, input logic [31:0] rt);
    @(posedge clk);
    #1;
    bus.start = 1'b1;
    bus.func = f;
    bus.rs_data = rs;
    bus.rt_data = rt;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask
  task automatic wait_done();
    int n = 0;
    while (bus.done !== 1'b1 && n < 80) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 80) begin
      checks++;
      errs++;
      $display("FAIL done_timeout: got no done within %0d cycles expected done", n);
    end
    @(posedge clk);
    #1;
  endtask
  task automatic run(input logic [5:0] f, input logic [31:0] rs, input logic [31:0] rt,
                     input logic [31:0] ehi, input logic [31:0] elo, input logic edz, input int lat);
    sb.push_back('{hi: ehi, lo: elo, dz: edz, lat: lat});
    issue(f, rs, rt);
    wait_done();
  endtask
  initial begin
    reset = 1'b1;
    bus.start = 1'b0;
    bus.func = '0;
    bus.rs_data = '0;
    bus.rt_data = '0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    chk("rst_busy", {31'b0, bus.busy}, 32'd0);
    chk("rst_done", {31'b0, bus.done}, 32'd0);
    chk("rst_dz", {31'b0, bus.div_zero}, 32'd0);
    chk("rst_hi", bus.hi, 32'd0);
    chk("rst_lo", bus.lo, 32'd0);
    run(MULT, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 34);
    run(DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 34);
    run(DIV, 32'd7, 32'hFFFFFFFE, 32'd1, 32'hFFFFFFFD, 1'b0, 34);
    run(DIV, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000, 1'b0, 34);
    run(MULT, 32'h80000000, 32'h80000000, 32'h40000000, 32'd0, 1'b0, 34);
    run(MULT, 32'hFFFFFFFB, 32'hFFFFFFFB, 32'd0, 32'd25, 1'b0, 34);
    run(DIV, 32'd5, 32'd0, 32'd5, 32'hFFFFFFFF, 1'b1, 1);
    run(MULT, 32'd2, 32'd3, 32'd0, 32'd6, 1'b0, 34);
    sb.push_back('{hi: 32'd0, lo: 32'd3000, dz: 1'b0, lat: 34});
    issue(MULT, 32'd1000, 32'd3);
    repeat (9) @(posedge clk);
    #1;
    bus.start = 1'b1;
    bus.func = DIV;
    bus.rs_data = 32'd9;
    bus.rt_data = 32'd0;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    wait_done();
    issue(ADD, 32'd1, 32'd2);
    chk("add_busy", {31'b0, bus.busy}, 32'd0);
    @(posedge clk);
    #1;
    chk("add_busy_later", {31'b0, bus.busy}, 32'd0);
    chk("add_hi", bus.hi, 32'd0);
    chk("add_lo", bus.lo, 32'd3000);
    issue(MULT, 32'd123, 32'd456);
    repeat (14) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk("abort_busy", {31'b0, bus.busy}, 32'd0);
    chk("abort_done", {31'b0, bus.done}, 32'd0);
    chk("abort_hi", bus.hi, 32'd0);
    chk("abort_lo", bus.lo, 32'd0);
    run(DIV, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 34);
    repeat (3) @(posedge clk);
    chk("scoreboard_empty", sb.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
